// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared widths, defaults and response entry type for the sram-like responder
package sram_like_pkg;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_STRB_W = 4;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_RAM_AW  = 16;
    typedef struct packed {
        logic [SRAM_DATA_W-1:0] rdata;
    } rsp_entry_t;
endpackage

// File: rtl/sram_like_responder_if.sv
// sram_like_responder_if: req/addr_ok/data_ok bus between a requester and the responder
interface sram_like_responder_if;
    import sram_like_pkg::*;
    logic                   req;
    logic                   wr;
    logic [SRAM_STRB_W-1:0] wstrb;
    logic [31:0]            addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic                   addr_ok;
    logic                   data_ok;
    logic [SRAM_DATA_W-1:0] rdata;
    modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_responder_rsp_fifo.sv
// rsp_fifo: synchronous FIFO holding in-order responses; pointers wrap modulo DEPTH
module rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = push ? AW'((32'(wr_ptr_q) + 1) % DEPTH) : wr_ptr_q;
        rd_ptr_d = pop ? AW'((32'(rd_ptr_q) + 1) % DEPTH) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: in-order sram-like responder in front of a 1-cycle synchronous RAM.
// Define SRAM_RSP_RAND_DELAY_EN to add LFSR-driven random back-pressure on both phases.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int          DEPTH     = DEF_DEPTH,
    parameter int          RAM_AW    = DEF_RAM_AW,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_like_responder_if.slave     bus,
    output logic                     ram_en,
    output logic [SRAM_STRB_W-1:0]   ram_we,
    output logic [RAM_AW-1:0]        ram_addr,
    output logic [SRAM_DATA_W-1:0]   ram_wdata,
    input  logic [SRAM_DATA_W-1:0]   ram_rdata
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          infl_q, infl_d, infl_wr_q, infl_wr_d;
    logic          stall_a, stall_d, hs, fifo_empty;
    rsp_entry_t    push_entry, head_entry;
    logic [CW-1:0] fifo_count;
    logic          unused_ok;
`ifdef SRAM_RSP_RAND_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb begin
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall_a = lfsr_q[0] & lfsr_q[3];
        stall_d = lfsr_q[1] & lfsr_q[5];
    end
    always_ff @(posedge clk) lfsr_q <= rst ? LFSR_SEED : lfsr_d;
`else
    assign stall_a = 1'b0;
    assign stall_d = 1'b0;
`endif
    always_comb begin
        bus.addr_ok      = bus.req & (cnt_q < CW'(DEPTH)) & ~stall_a;
        hs               = bus.req & bus.addr_ok;
        ram_en           = hs;
        ram_we           = (bus.wr & hs) ? bus.wstrb : '0;
        ram_addr         = bus.addr[RAM_AW+1:2];
        ram_wdata        = bus.wdata;
        bus.data_ok      = ~fifo_empty & ~stall_d;
        bus.rdata        = bus.data_ok ? head_entry.rdata : '0;
        cnt_d            = cnt_q + CW'(hs) - CW'(bus.data_ok);
        infl_d           = hs;
        infl_wr_d        = bus.wr;
        push_entry.rdata = infl_wr_q ? '0 : ram_rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            infl_q    <= 1'b0;
            infl_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            infl_q    <= infl_d;
            infl_wr_q <= infl_wr_d;
        end
    end
    // Occupancy never exceeds cnt, so the FIFO cannot overflow.
    rsp_fifo #(.DEPTH(DEPTH), .WIDTH($bits(rsp_entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (infl_q),
        .pop   (bus.data_ok),
        .din   (push_entry),
        .dout  (head_entry),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    assign unused_ok = ^{bus.addr[1:0], bus.addr[31:RAM_AW+2], fifo_count, LFSR_SEED};
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: directed table-driven bench plus multi-cycle sequences (reset, full stall)
module tb_sram_like_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_like_responder_if b ();
    sram_like_responder_if b2 ();

    logic        ram_en, ram_en2;
    logic [3:0]  ram_we, ram_we2;
    logic [15:0] ram_addr, ram_addr2;
    logic [31:0] ram_wdata, ram_wdata2, ram_rdata, ram_rdata2;
    logic [31:0] mem [256];

    sram_like_responder u_dut (
        .clk(clk), .rst(rst), .bus(b), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );
    sram_like_responder #(.DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(b2), .ram_en(ram_en2), .ram_we(ram_we2),
        .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
    );

    // Read-first byte-write RAM; contents reloaded on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | i;
            mem[16]   <= 32'h1234_5678;
            mem[2]    <= 32'h1111_2222;
            ram_rdata <= '0;
        end else if (ram_en) begin
            for (int j = 0; j < 4; j++) if (ram_we[j]) mem[ram_addr[7:0]][8*j +: 8] <= ram_wdata[8*j +: 8];
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end
    always @(posedge clk) ram_rdata2 <= rst ? 32'h0 : (ram_en2 ? {16'hD0D0, ram_addr2} : ram_rdata2);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic wr, input logic [3:0] wstrb,
                         input logic [31:0] addr, input logic [31:0] wdata);
        b.req = req; b.wr = wr; b.wstrb = wstrb; b.addr = addr; b.wdata = wdata;
    endtask

    typedef struct {
        logic        req, wr;
        logic [3:0]  wstrb;
        logic [31:0] addr, wdata;
        logic        aok, dok;
        logic [31:0] rdata;
        logic        en;
        logic [3:0]  we;
        logic [15:0] raddr;
    } vec_t;

    function automatic vec_t mk(logic req, logic wr, logic [3:0] wstrb, logic [31:0] addr,
                                logic [31:0] wdata, logic aok, logic dok, logic [31:0] rdata,
                                logic en, logic [3:0] we, logic [15:0] raddr);
        vec_t v;
        v.req = req; v.wr = wr; v.wstrb = wstrb; v.addr = addr; v.wdata = wdata;
        v.aok = aok; v.dok = dok; v.rdata = rdata; v.en = en; v.we = we; v.raddr = raddr;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin
        logic [8:0]  e_aok;
        logic [8:0]  e_dok;
        int          idx, k, seen;
        logic        acc;
        vecs[0]  = mk(1, 0, 4'h0, 32'h40, 0, 1, 0, 32'h0,         1, 4'h0, 16'h10);
        vecs[1]  = mk(0, 0, 4'h0, 32'h0,  0, 0, 0, 32'h0,         0, 4'h0, 16'h0);
        vecs[2]  = mk(0, 0, 4'h0, 32'h0,  0, 0, 1, 32'h1234_5678, 0, 4'h0, 16'h0);
        vecs[3]  = mk(0, 0, 4'h0, 32'h0,  0, 0, 0, 32'h0,         0, 4'h0, 16'h0);
        vecs[4]  = mk(1, 0, 4'h0, 32'h0,  0, 1, 0, 32'h0,         1, 4'h0, 16'h0);
        vecs[5]  = mk(1, 0, 4'h0, 32'h4,  0, 1, 0, 32'h0,         1, 4'h0, 16'h1);
        vecs[6]  = mk(1, 0, 4'h0, 32'h8,  0, 1, 1, 32'hC0DE_0000, 1, 4'h0, 16'h2);
        vecs[7]  = mk(1, 0, 4'h0, 32'hC,  0, 1, 1, 32'hC0DE_0001, 1, 4'h0, 16'h3);
        vecs[8]  = mk(0, 0, 4'h0, 32'h0,  0, 0, 1, 32'h1111_2222, 0, 4'h0, 16'h0);
        vecs[9]  = mk(0, 0, 4'h0, 32'h0,  0, 0, 1, 32'hC0DE_0003, 0, 4'h0, 16'h0);
        vecs[10] = mk(0, 0, 4'h0, 32'h0,  0, 0, 0, 32'h0,         0, 4'h0, 16'h0);
        vecs[11] = mk(1, 1, 4'h3, 32'h8,  32'hAAAA_BBBB, 1, 0, 32'h0, 1, 4'h3, 16'h2);
        vecs[12] = mk(0, 0, 4'h0, 32'h0,  0, 0, 0, 32'h0,         0, 4'h0, 16'h0);
        vecs[13] = mk(0, 0, 4'h0, 32'h0,  0, 0, 1, 32'h0,         0, 4'h0, 16'h0);
        vecs[14] = mk(1, 0, 4'h0, 32'h8,  0, 1, 0, 32'h0,         1, 4'h0, 16'h2);
        vecs[15] = mk(0, 0, 4'h0, 32'h0,  0, 0, 0, 32'h0,         0, 4'h0, 16'h0);
        vecs[16] = mk(0, 0, 4'h0, 32'h0,  0, 0, 1, 32'h1111_BBBB, 0, 4'h0, 16'h0);
        vecs[17] = mk(0, 0, 4'h0, 32'h0,  0, 0, 0, 32'h0,         0, 4'h0, 16'h0);

        rst = 1'b1;
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        b2.req = 0; b2.wr = 0; b2.wstrb = 4'h0; b2.addr = 32'h0; b2.wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset addr_ok", 32'(b.addr_ok), 32'h0);
        chk("reset data_ok", 32'(b.data_ok), 32'h0);
        chk("reset rdata", b.rdata, 32'h0);
        chk("reset ram_en", 32'(ram_en), 32'h0);
        chk("reset ram_we", 32'(ram_we), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].req, vecs[i].wr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d addr_ok", i), 32'(b.addr_ok), 32'(vecs[i].aok));
            chk($sformatf("v%0d data_ok", i), 32'(b.data_ok), 32'(vecs[i].dok));
            chk($sformatf("v%0d rdata", i), b.rdata, vecs[i].rdata);
            chk($sformatf("v%0d ram_en", i), 32'(ram_en), 32'(vecs[i].en));
            chk($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vecs[i].we));
            chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].raddr));
            @(posedge clk);
            #1;
        end

        // Reset lands while two reads are in flight: neither may respond.
        drive(1, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("midrst first addr_ok", 32'(b.addr_ok), 32'h1);
        @(posedge clk);
        #1 drive(1, 0, 4'h0, 32'h4, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b.data_ok) seen++;
            if (i == 0) chk("midrst addr_ok idle", 32'(b.addr_ok), 32'h0);
        end
        chk("midrst stale data_ok count", 32'(seen), 32'h0);
        @(posedge clk);
        #1 drive(1, 0, 4'h0, 32'h40, 32'h0);
        @(negedge clk);
        chk("postrst addr_ok", 32'(b.addr_ok), 32'h1);
        @(posedge clk);
        #1 drive(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("postrst data_ok N+1", 32'(b.data_ok), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("postrst data_ok N+2", 32'(b.data_ok), 32'h1);
        chk("postrst rdata N+2", b.rdata, 32'h1234_5678);
        @(posedge clk);
        #1;

        // DEPTH=2 instance: five reads, addr_ok drops whenever two are outstanding.
        e_aok = 9'b001011011;
        e_dok = 9'b101101100;
        idx = 0;
        k = 0;
        for (int c = 0; c < 9; c++) begin
            b2.req  = (idx < 5);
            b2.addr = 32'(idx * 4);
            @(negedge clk);
            chk($sformatf("full c%0d addr_ok", c), 32'(b2.addr_ok), 32'(e_aok[c]));
            chk($sformatf("full c%0d data_ok", c), 32'(b2.data_ok), 32'(e_dok[c]));
            if (b2.data_ok) begin
                chk($sformatf("full c%0d rdata", c), b2.rdata, 32'hD0D0_0000 | k);
                k++;
            end
            acc = b2.req & b2.addr_ok;
            @(posedge clk);
            #1 if (acc) idx++;
        end
        chk("full responses", 32'(k), 32'h5);
        b2.req = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
